// File: rtl/ps2_key_decoder_pkg.sv
// ps2_pkg: shared types, scan-code constants and lookup functions for the
// PS/2 set-2 key decoder.
//   state_e        - pop sequencer states (IDLE -> POP -> GAP)
//   SC_*           - prefix and shift scan codes
//   scan_to_ascii  - set-2 scan code to ASCII (A-Z, 0-9 only)
//   hex_to_seg     - nibble to active-low 7-segment pattern (a..g, dp)
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // Letters resolve to lowercase first; 'upper' shifts them by 0x20.
    // Digits ignore 'upper'. Anything else maps to 0.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code,
                                                 input logic       upper);
        logic [7:0] letter;
        logic [7:0] result;
        letter = 8'h00;
        result = 8'h00;
        case (code)
            8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;
            8'h21: letter = 8'h63;  8'h23: letter = 8'h64;
            8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67;  8'h33: letter = 8'h68;
            8'h43: letter = 8'h69;  8'h3B: letter = 8'h6A;
            8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;
            8'h44: letter = 8'h6F;  8'h4D: letter = 8'h70;
            8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;
            8'h3C: letter = 8'h75;  8'h2A: letter = 8'h76;
            8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
            8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
            8'h45: result = 8'h30;  8'h16: result = 8'h31;
            8'h1E: result = 8'h32;  8'h26: result = 8'h33;
            8'h25: result = 8'h34;  8'h2E: result = 8'h35;
            8'h36: result = 8'h36;  8'h3D: result = 8'h37;
            8'h3E: result = 8'h38;  8'h46: result = 8'h39;
            default: result = 8'h00;
        endcase
        if (letter != 8'h00) begin
            result = upper ? (letter - 8'h20) : letter;
        end else begin
            result = result;
        end
        return result;
    endfunction

    // Active-low segments: bit7=a ... bit1=g, bit0=dp (dp always dark).
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'h03;  4'h1: seg = 8'h9F;
            4'h2: seg = 8'h25;  4'h3: seg = 8'h0D;
            4'h4: seg = 8'h99;  4'h5: seg = 8'h49;
            4'h6: seg = 8'h41;  4'h7: seg = 8'h1F;
            4'h8: seg = 8'h01;  4'h9: seg = 8'h09;
            4'hA: seg = 8'h11;  4'hB: seg = 8'hC1;
            4'hC: seg = 8'h63;  4'hD: seg = 8'h85;
            4'hE: seg = 8'h61;  4'hF: seg = 8'h71;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_kb_if: read port of the ps2_keyboard scan-code FIFO.
//   kb_data       - head byte, valid while kb_ready=1
//   kb_ready      - FIFO non-empty
//   kb_overflow   - FIFO overflow flag
//   kb_nextdata_n - active-low pop strobe from the consumer
// master = keyboard FIFO side, slave = decoder side.
interface ps2_kb_if;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_overflow;
    logic       kb_nextdata_n;

    modport master (output kb_data, output kb_ready, output kb_overflow,
                    input  kb_nextdata_n);
    modport slave  (input  kb_data, input  kb_ready, input  kb_overflow,
                    output kb_nextdata_n);
endinterface

// File: rtl/ps2_key_decoder_hex7seg.sv
// hex7seg: combinational nibble to active-low seven-segment pattern.
//   hex_i [3:0] - hex digit
//   seg_o [7:0] - a..g in bits 7..1, dp in bit 0, active-low
module hex7seg
    import ps2_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [7:0] seg_o
);

    // Pure table lookup; the parent registers the result.
    always_comb begin
        seg_o = hex_to_seg(hex_i);
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: pops PS/2 set-2 scan codes from the keyboard FIFO one at a
// time, tracks break/extended prefixes, shift keys, the held key and a press
// counter, and drives eight active-low seven-segment digits.
//   clk, resetn      - clock, synchronous active-low reset
//   kb (slave)       - keyboard FIFO read port
//   key_held         - a non-shift make is active
//   key_code         - scan code of the held or last key
//   key_ascii        - ASCII of key_code, 0 if unmapped/extended
//   key_count        - number of distinct presses (wraps)
//   o_seg0..o_seg7   - digits: 1:0 code, 3:2 ascii, 5:4 blank, 7:6 count
// Pipeline: capture at edge N, pop/decode at N+1, key_* at N+2, segs at N+3.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter logic [7:0] SEG_BLANK = 8'hFF
) (
    input  logic       clk,
    input  logic       resetn,
    ps2_kb_if.slave    kb,
    output logic       key_held,
    output logic [7:0] key_code,
    output logic [7:0] key_ascii,
    output logic [7:0] key_count,
    output logic [7:0] o_seg0,
    output logic [7:0] o_seg1,
    output logic [7:0] o_seg2,
    output logic [7:0] o_seg3,
    output logic [7:0] o_seg4,
    output logic [7:0] o_seg5,
    output logic [7:0] o_seg6,
    output logic [7:0] o_seg7
);

    state_e     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic       shift_l_q, shift_l_d;
    logic       shift_r_q, shift_r_d;
    logic       nextdata_n_q, nextdata_n_d;
    logic       held_q, held_d;
    logic [7:0] code_q, code_d;
    logic [7:0] ascii_q, ascii_d;
    logic [7:0] count_q, count_d;

    logic [7:0] seg_code_lo_s, seg_code_hi_s;
    logic [7:0] seg_ascii_lo_s, seg_ascii_hi_s;
    logic [7:0] seg_count_lo_s, seg_count_hi_s;

    // Overflow is deliberately not acted on; decoding continues regardless.
    logic unused_overflow_s;
    assign unused_overflow_s = kb.kb_overflow;

    assign kb.kb_nextdata_n = nextdata_n_q;

    // Sequencer and decoder state registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            byte_q       <= 8'h00;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            shift_l_q    <= 1'b0;
            shift_r_q    <= 1'b0;
            nextdata_n_q <= 1'b1;
            held_q       <= 1'b0;
            code_q       <= 8'h00;
            ascii_q      <= 8'h00;
            count_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            shift_l_q    <= shift_l_d;
            shift_r_q    <= shift_r_d;
            nextdata_n_q <= nextdata_n_d;
            held_q       <= held_d;
            code_q       <= code_d;
            ascii_q      <= ascii_d;
            count_q      <= count_d;
        end
    end

    // Next-state: capture in IDLE, decode the captured byte in POP, settle in GAP.
    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        brk_d        = brk_q;
        ext_d        = ext_q;
        shift_l_d    = shift_l_q;
        shift_r_d    = shift_r_q;
        nextdata_n_d = 1'b1;
        held_d       = held_q;
        code_d       = code_q;
        ascii_d      = ascii_q;
        count_d      = count_q;
        case (state_q)
            ST_IDLE: begin
                if (kb.kb_ready) begin
                    byte_d       = kb.kb_data;
                    nextdata_n_d = 1'b0;   // strobe is registered, so it lines up with POP
                    state_d      = ST_POP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_POP: begin
                state_d = ST_GAP;
                if (byte_q == SC_BREAK) begin
                    brk_d = 1'b1;
                end else if (byte_q == SC_EXT) begin
                    ext_d = 1'b1;
                end else if ((byte_q == SC_LSHIFT) || (byte_q == SC_RSHIFT)) begin
                    if (byte_q == SC_LSHIFT) begin
                        shift_l_d = ~brk_q;
                    end else begin
                        shift_r_d = ~brk_q;
                    end
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end else if (brk_q) begin
                    // Releasing some other key leaves the held one alone.
                    if (byte_q == code_q) begin
                        held_d = 1'b0;
                    end else begin
                        held_d = held_q;
                    end
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end else begin
                    // Typematic repeats of the held key are not new presses.
                    if (!held_q || (byte_q != code_q)) begin
                        count_d = count_q + 8'd1;
                    end else begin
                        count_d = count_q;
                    end
                    code_d  = byte_q;
                    held_d  = 1'b1;
                    ascii_d = ext_q ? 8'h00 : scan_to_ascii(byte_q, shift_l_q | shift_r_q);
                    ext_d   = 1'b0;
                end
            end
            ST_GAP: begin
                // kb_ready needs this cycle to reflect the post-pop head.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered key outputs, one stage behind the decoder state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_held  <= 1'b0;
            key_code  <= 8'h00;
            key_ascii <= 8'h00;
            key_count <= 8'h00;
        end else begin
            key_held  <= held_q;
            key_code  <= code_q;
            key_ascii <= ascii_q;
            key_count <= count_q;
        end
    end

    hex7seg u_code_lo  (.hex_i(key_code[3:0]),  .seg_o(seg_code_lo_s));
    hex7seg u_code_hi  (.hex_i(key_code[7:4]),  .seg_o(seg_code_hi_s));
    hex7seg u_ascii_lo (.hex_i(key_ascii[3:0]), .seg_o(seg_ascii_lo_s));
    hex7seg u_ascii_hi (.hex_i(key_ascii[7:4]), .seg_o(seg_ascii_hi_s));
    hex7seg u_count_lo (.hex_i(key_count[3:0]), .seg_o(seg_count_lo_s));
    hex7seg u_count_hi (.hex_i(key_count[7:4]), .seg_o(seg_count_hi_s));

    // Registered digit drivers; code/ascii digits go dark when no key is held.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            o_seg0 <= SEG_BLANK;
            o_seg1 <= SEG_BLANK;
            o_seg2 <= SEG_BLANK;
            o_seg3 <= SEG_BLANK;
            o_seg4 <= SEG_BLANK;
            o_seg5 <= SEG_BLANK;
            o_seg6 <= hex_to_seg(4'h0);
            o_seg7 <= hex_to_seg(4'h0);
        end else begin
            o_seg0 <= key_held ? seg_code_lo_s  : SEG_BLANK;
            o_seg1 <= key_held ? seg_code_hi_s  : SEG_BLANK;
            o_seg2 <= key_held ? seg_ascii_lo_s : SEG_BLANK;
            o_seg3 <= key_held ? seg_ascii_hi_s : SEG_BLANK;
            o_seg4 <= SEG_BLANK;
            o_seg5 <= SEG_BLANK;
            o_seg6 <= seg_count_lo_s;
            o_seg7 <= seg_count_hi_s;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: a queue models the keyboard FIFO, and a
// scan-code-level reference model predicts key state and digit patterns.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       key_held;
    logic [7:0] key_code, key_ascii, key_count;
    logic [7:0] o_seg0, o_seg1, o_seg2, o_seg3, o_seg4, o_seg5, o_seg6, o_seg7;

    always #5 clk = ~clk;

    ps2_kb_if kb();

    ps2_key_decoder #(.SEG_BLANK(8'hFF)) dut (
        .clk(clk), .resetn(resetn), .kb(kb),
        .key_held(key_held), .key_code(key_code),
        .key_ascii(key_ascii), .key_count(key_count),
        .o_seg0(o_seg0), .o_seg1(o_seg1), .o_seg2(o_seg2), .o_seg3(o_seg3),
        .o_seg4(o_seg4), .o_seg5(o_seg5), .o_seg6(o_seg6), .o_seg7(o_seg7)
    );

    int checks = 0;
    int errors = 0;

    // keyboard FIFO model and pop-strobe monitor
    logic [7:0] fifo_q[$];
    int cyc = 0;
    int pulses = 0;
    int last_pulse = -10;
    int spacing_err = 0;

    // reference model state
    logic       m_brk, m_ext, m_shl, m_shr, m_held;
    logic [7:0] m_code, m_ascii, m_count;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
        8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
        8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
        8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49,
        8'h41, 8'h1F, 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    initial begin
        kb.kb_data = 8'h00;
        kb.kb_ready = 1'b0;
        kb.kb_overflow = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (kb.kb_nextdata_n === 1'b0) begin
                pulses++;
                if (cyc - last_pulse < 3) spacing_err++;
                last_pulse = cyc;
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
            kb.kb_ready = (fifo_q.size() != 0);
            kb.kb_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
            kb.kb_overflow = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic up);
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == c) return (up ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == c) return 8'h30 + 8'(i);
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_brk = 1'b0; m_ext = 1'b0; m_shl = 1'b0; m_shr = 1'b0;
        m_held = 1'b0; m_code = 8'h00; m_ascii = 8'h00; m_count = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'h12 || b == 8'h59) begin
            if (b == 8'h12) m_shl = !m_brk; else m_shr = !m_brk;
            m_brk = 1'b0; m_ext = 1'b0;
        end else if (m_brk) begin
            if (b == m_code) m_held = 1'b0;
            m_brk = 1'b0; m_ext = 1'b0;
        end else begin
            if (!m_held || b != m_code) m_count = m_count + 8'd1;
            m_code = b; m_held = 1'b1;
            m_ascii = m_ext ? 8'h00 : ref_ascii(b, m_shl | m_shr);
            m_ext = 1'b0;
        end
    endtask

    function automatic logic [24:0] exp_key();
        return {m_held, m_code, m_ascii, m_count};
    endfunction

    function automatic logic [63:0] exp_segs();
        logic [7:0] s [8];
        s[0] = m_held ? seg_tab[m_code[3:0]]  : 8'hFF;
        s[1] = m_held ? seg_tab[m_code[7:4]]  : 8'hFF;
        s[2] = m_held ? seg_tab[m_ascii[3:0]] : 8'hFF;
        s[3] = m_held ? seg_tab[m_ascii[7:4]] : 8'hFF;
        s[4] = 8'hFF;
        s[5] = 8'hFF;
        s[6] = seg_tab[m_count[3:0]];
        s[7] = seg_tab[m_count[7:4]];
        return {s[7], s[6], s[5], s[4], s[3], s[2], s[1], s[0]};
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        resetn = 1'b0;
        fifo_q.delete();
        repeat (cycles) @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic send(input logic [7:0] b);
        fifo_q.push_back(b);
        model_byte(b);
    endtask

    // Wait until the FIFO is drained and the last byte has reached the digits.
    task automatic drain(input int budget);
        int n = 0;
        while (fifo_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fifo_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d bytes left, required 0", fifo_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        int p0;
        do_reset(2);
        p0 = pulses;
        repeat (10) @(negedge clk);
        checks++;
        if (pulses != p0) begin
            errors++; $display("FAIL reset_no_pop: pulses %0d, required 0", pulses - p0);
        end
        checks++;
        if ({key_held, key_code, key_ascii, key_count} !== 25'h0) begin
            errors++;
            $display("FAIL reset_key: got %h, required 0", {key_held, key_code, key_ascii, key_count});
        end
        checks++;
        if ({o_seg7, o_seg6, o_seg5, o_seg4, o_seg3, o_seg2, o_seg1, o_seg0} !== 64'h0303FFFFFFFFFFFF) begin
            errors++;
            $display("FAIL reset_seg: got %h, required 0303ffffffffffff",
                     {o_seg7, o_seg6, o_seg5, o_seg4, o_seg3, o_seg2, o_seg1, o_seg0});
        end
    endtask

    task automatic test_make_break();
        do_reset(1);
        send(8'h1C);
        drain(50);
        checks++;
        if ({key_held, key_code, key_ascii, key_count} !== {1'b1, 8'h1C, 8'h61, 8'h01}) begin
            errors++;
            $display("FAIL make_key: got %h, required %h", {key_held, key_code, key_ascii, key_count},
                     {1'b1, 8'h1C, 8'h61, 8'h01});
        end
        checks++;
        if ({o_seg1, o_seg0} !== 16'h9F63) begin
            errors++; $display("FAIL make_seg: got %h, required 9f63", {o_seg1, o_seg0});
        end
        send(8'hF0); send(8'h1C);
        drain(50);
        checks++;
        if ({key_held, key_code, key_count} !== {1'b0, 8'h1C, 8'h01}) begin
            errors++; $display("FAIL break_key: got %h, required 01c01", {key_held, key_code, key_count});
        end
        checks++;
        if ({o_seg7, o_seg6, o_seg5, o_seg4, o_seg3, o_seg2, o_seg1, o_seg0} !== exp_segs()) begin
            errors++; $display("FAIL break_seg: got %h, required %h",
                {o_seg7, o_seg6, o_seg5, o_seg4, o_seg3, o_seg2, o_seg1, o_seg0}, exp_segs());
        end
    endtask

    task automatic test_shift();
        do_reset(1);
        send(8'h12); send(8'h1C); send(8'h1C); send(8'h1C);
        drain(100);
        checks++;
        if ({key_ascii, key_count} !== {8'h41, 8'h01}) begin
            errors++; $display("FAIL shift_upper: got %h, required 4101", {key_ascii, key_count});
        end
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
        drain(100);
        checks++;
        if ({key_held, key_ascii, key_count} !== {1'b1, 8'h61, 8'h02}) begin
            errors++; $display("FAIL shift_cleared: got %h, required 16102", {key_held, key_ascii, key_count});
        end
    endtask

    task automatic test_extended();
        do_reset(1);
        send(8'hE0); send(8'h75);
        drain(50);
        checks++;
        if ({key_held, key_code, key_ascii, key_count} !== {1'b1, 8'h75, 8'h00, 8'h01}) begin
            errors++; $display("FAIL ext_make: got %h, required %h",
                {key_held, key_code, key_ascii, key_count}, {1'b1, 8'h75, 8'h00, 8'h01});
        end
        send(8'hE0); send(8'hF0); send(8'h75); send(8'h16);
        drain(80);
        checks++;
        if ({key_held, key_code, key_ascii, key_count} !== {1'b1, 8'h16, 8'h31, 8'h02}) begin
            errors++; $display("FAIL ext_then_digit: got %h, required %h",
                {key_held, key_code, key_ascii, key_count}, {1'b1, 8'h16, 8'h31, 8'h02});
        end
    endtask

    task automatic test_latency();
        int n = 0;
        do_reset(1);
        send(8'h1C);
        while (kb.kb_nextdata_n !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (kb.kb_nextdata_n !== 1'b0) begin
            errors++; $display("FAIL lat_pop: no pop strobe, required one within 20 cycles");
        end
        @(negedge clk);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL lat_early: key_held %b at N+1, required 0", key_held);
        end
        @(negedge clk);
        checks++;
        if ({key_held, o_seg0} !== {1'b1, 8'hFF}) begin
            errors++; $display("FAIL lat_key: held/seg0 %h at N+2, required 1ff", {key_held, o_seg0});
        end
        @(negedge clk);
        checks++;
        if (o_seg0 !== 8'h63) begin
            errors++; $display("FAIL lat_seg: seg0 %h at N+3, required 63", o_seg0);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] b;
        do_reset(1);
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0: b = 8'hF0;
                1: b = 8'hE0;
                2: b = 8'h12;
                3: b = 8'h59;
                4, 5: b = letter_codes[$urandom_range(0, 25)];
                6: b = digit_codes[$urandom_range(0, 9)];
                7: b = m_code;
                default: b = 8'($urandom);
            endcase
            send(b);
            drain(30);
            checks++;
            if ({key_held, key_code, key_ascii, key_count} !== exp_key()) begin
                errors++; $display("FAIL rand_key[%0d] byte %h: got %h, required %h", i, b,
                    {key_held, key_code, key_ascii, key_count}, exp_key());
            end
            checks++;
            if ({o_seg7, o_seg6, o_seg5, o_seg4, o_seg3, o_seg2, o_seg1, o_seg0} !== exp_segs()) begin
                errors++; $display("FAIL rand_seg[%0d]: got %h, required %h", i,
                    {o_seg7, o_seg6, o_seg5, o_seg4, o_seg3, o_seg2, o_seg1, o_seg0}, exp_segs());
            end
        end
    endtask

    task automatic test_back_to_back();
        int p0, s0;
        logic [7:0] c;
        do_reset(1);
        p0 = pulses;
        s0 = spacing_err;
        for (int i = 0; i < 256; i++) begin
            c = 8'($urandom);
            while (c == 8'hF0 || c == 8'hE0 || c == 8'h12 || c == 8'h59) c = 8'($urandom);
            send(c); send(8'hF0); send(c);
        end
        drain(3000);
        checks++;
        if (key_count !== m_count || m_count !== 8'h00) begin
            errors++; $display("FAIL wrap_count: got %h, required 00 (model %h)", key_count, m_count);
        end
        checks++;
        if (pulses - p0 != 768) begin
            errors++; $display("FAIL pop_pulses: got %0d, required 768", pulses - p0);
        end
        checks++;
        if (spacing_err != s0) begin
            errors++; $display("FAIL pop_spacing: %0d pulses closer than 3 cycles, required 0", spacing_err - s0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        send(8'hF0);
        drain(30);
        do_reset(1);
        send(8'h1C);
        drain(30);
        checks++;
        if ({key_held, key_code, key_count} !== {1'b1, 8'h1C, 8'h01}) begin
            errors++; $display("FAIL reset_mid: got %h, required 11c01", {key_held, key_code, key_count});
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_make_break();
        test_shift();
        test_extended();
        test_latency();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
